// File: rtl/credit_receiver_fifo_if.sv
// Link-side bundle of the credit receiver: credited push channel from the
// sender and valid/ready pop channel towards the consumer.
interface credit_receiver_fifo_if #(
    parameter int WIDTH = 8
);
    logic             push_sender_in_reset;
    logic             push_receiver_in_reset;
    logic             push_credit_stall;
    logic             push_credit;
    logic             push_valid;
    logic [WIDTH-1:0] push_data;
    logic             pop_valid;
    logic             pop_ready;
    logic [WIDTH-1:0] pop_data;

    // The master drives beats in and pulls entries out; the slave is the receiver.
    modport master (
        output push_sender_in_reset, push_credit_stall, push_valid, push_data, pop_ready,
        input  push_receiver_in_reset, push_credit, pop_valid, pop_data
    );

    modport slave (
        input  push_sender_in_reset, push_credit_stall, push_valid, push_data, pop_ready,
        output push_receiver_in_reset, push_credit, pop_valid, pop_data
    );
endinterface

// File: rtl/credit_receiver_fifo.sv
// Receive end of a credited link: holds up to DEPTH credits, buffers beats in a
// DEPTH-entry FIFO and hands one credit back for every entry consumed.
module credit_receiver_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    credit_receiver_fifo_if.slave link,
    input  logic [CW-1:0]         credit_initial,
    input  logic [CW-1:0]         credit_withhold,
    output logic [CW-1:0]         credit_count,
    output logic [CW-1:0]         credit_available,
    output logic                  credit_error
);
    localparam int              IW      = $clog2(DEPTH);
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [IW-1:0]   LAST    = IW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [IW-1:0]    head;
    logic [IW-1:0]    tail;
    logic [CW-1:0]    occupancy;
    logic             lr;
    logic             full;
    logic             push_ok;
    logic             pop_ok;
    logic [CW:0]      credit_sum;

    assign lr      = rst | link.push_sender_in_reset;
    assign full    = (occupancy == DEPTH_C);
    assign push_ok = link.push_valid & ~lr & ~full;
    assign pop_ok  = link.pop_valid & link.pop_ready & ~lr;

    assign link.push_receiver_in_reset = rst;
    assign link.pop_valid              = (occupancy != '0);
    assign link.pop_data               = mem[head];

    assign credit_available = (credit_count > credit_withhold) ? (credit_count - credit_withhold) : '0;
    assign link.push_credit = ~lr & ~link.push_credit_stall & (credit_available != '0);

    // Widened so a pop on a counter already at DEPTH can be seen and clamped.
    assign credit_sum = {1'b0, credit_count} + {{CW{1'b0}}, pop_ok} - {{CW{1'b0}}, link.push_credit};

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
    always_ff @(posedge clk) begin
        if (lr) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else begin
            if (push_ok) begin
                tail <= (tail == LAST) ? '0 : tail + IW'(1);
            end
            if (pop_ok) begin
                head <= (head == LAST) ? '0 : head + IW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   occupancy <= occupancy + CW'(1);
                2'b01:   occupancy <= occupancy - CW'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[tail] <= link.push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (lr) begin
            credit_count <= credit_initial;
        end else if (credit_sum > {1'b0, DEPTH_C}) begin
            credit_count <= DEPTH_C;
        end else begin
            credit_count <= credit_sum[CW-1:0];
        end
    end

    // Overflow flag survives a sender-side reset; only the local reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_error <= 1'b0;
        end else if (link.push_valid & ~lr & full) begin
            credit_error <= 1'b1;
        end
    end

    // Credits held plus entries buffered can never exceed what the link started with.
    assert property (@(posedge clk) disable iff (lr)
        (occupancy <= DEPTH_C) && (credit_count <= DEPTH_C) &&
        (({1'b0, credit_count} + {1'b0, occupancy}) <= {1'b0, DEPTH_C}));
endmodule
